// File: rtl/seq_shift_unit.sv
// Iterative shift unit: start/done handshake, one bit per SHIFT cycle by default.
// Define SHIFT_FAST_EN to shift up to four bits per cycle (same results, shorter latency).
module seq_shift_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  logic [1:0]       alufn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [1:0]       type_q, type_d;
    logic [WIDTH-1:0] r_q, r_d;

    logic [SHW-1:0]   step;
    logic [WIDTH-1:0] shifted;

    always_comb begin
`ifdef SHIFT_FAST_EN
        step = (count_q > SHW'(4)) ? SHW'(4) : count_q;
`else
        step = SHW'(1);
`endif
    end

    always_comb begin
        shifted = work_q;
        case (type_q)
            2'b00:   shifted = work_q >> step;
            2'b01:   shifted = work_q << step;
            2'b10:   shifted = $signed(work_q) >>> step;
            default: shifted = work_q;
        endcase
    end

    // IDLE and DONE accept a new operation identically; kill always suppresses acceptance.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        work_d  = work_q;
        type_d  = type_q;
        r_d     = r_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start && !kill) begin
                    work_d  = a;
                    count_d = shamt;
                    type_d  = alufn;
                    if (shamt == '0) begin
                        state_d = DONE;
                        r_d     = a;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    work_d  = shifted;
                    count_d = count_q - step;
                    // r is loaded on the way into DONE so it is valid alongside done.
                    if (count_q == step) begin
                        state_d = DONE;
                        r_d     = shifted;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            work_q  <= '0;
            type_q  <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            work_q  <= work_d;
            type_q  <= type_d;
            r_q     <= r_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign r    = r_q;

endmodule
